// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard detection unit
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 32;

endpackage

// File: rtl/reg_match.sv
// rtl/reg_match.sv - true when a source register is nonzero and equals the EX destination
module reg_match
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] dst,
    output logic       hit
);

    assign hit = (src != REG_ZERO) && (src == dst);

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use / branch hazard stall and memory-wait freeze control
// Optional stall-cycle counter built only when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit
    import hazard_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             ID_rs,
    input  logic [4:0]             ID_rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_Branch,
    input  logic                   EX_RegWrite,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_WriteRegister,
    input  logic                   MEM_Busy,
    output logic                   PCWrite,
    output logic                   IF_ID_Write,
    output logic                   ID_EX_Bubble,
    output logic                   Pipe_Freeze,
    output logic [STALL_CNT_W-1:0] StallCount
);

    hazard_state_t state, state_next;
    logic [1:0]    bub_cnt, bub_next;
    logic          hit_rs, hit_rt, match;
    logic          load_hz, alu_br_hz;
    logic          pc_c, ifid_c, bubble_c, freeze_c;

    reg_match u_match_rs (.src(ID_rs), .dst(EX_WriteRegister), .hit(hit_rs));
    reg_match u_match_rt (.src(ID_rt), .dst(EX_WriteRegister), .hit(hit_rt));

    assign match     = hit_rs || (ID_UsesRt && hit_rt);
    assign load_hz   = EX_MemRead && match;
    assign alu_br_hz = ID_Branch && EX_RegWrite && !EX_MemRead && match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            state   <= state_next;
            bub_cnt <= bub_next;
        end
    end

    always_comb begin
        state_next = state;
        bub_next   = bub_cnt;
        pc_c       = 1'b1;
        ifid_c     = 1'b1;
        bubble_c   = 1'b0;
        freeze_c   = 1'b0;
        case (state)
            // MEM_WAIT behaves like RUN once memory completes, so a hazard
            // visible in that release cycle is still caught.
            RUN, MEM_WAIT: begin
                if (MEM_Busy) begin
                    state_next = MEM_WAIT;
                    freeze_c   = 1'b1;
                    pc_c       = 1'b0;
                    ifid_c     = 1'b0;
                end else if (load_hz || alu_br_hz) begin
                    pc_c       = 1'b0;
                    ifid_c     = 1'b0;
                    bubble_c   = 1'b1;
                    if (load_hz && ID_Branch) begin
                        bub_next   = 2'd1;
                        state_next = STALL;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = RUN;
                end
            end
            STALL: begin
                pc_c   = 1'b0;
                ifid_c = 1'b0;
                // A busy memory freezes the pipe without consuming a bubble.
                if (MEM_Busy) begin
                    freeze_c = 1'b1;
                end else begin
                    bubble_c = 1'b1;
                    if (bub_cnt <= 2'd1) begin
                        bub_next   = 2'd0;
                        state_next = RUN;
                    end else begin
                        bub_next = bub_cnt - 2'd1;
                    end
                end
            end
            default: begin
                state_next = RUN;
                bub_next   = 2'd0;
            end
        endcase
    end

    // Reset forces run values regardless of what the ID/EX inputs show.
    assign PCWrite      = !rst_n || pc_c;
    assign IF_ID_Write  = !rst_n || ifid_c;
    assign ID_EX_Bubble = rst_n && bubble_c;
    assign Pipe_Freeze  = rst_n && freeze_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!PCWrite && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - directed-vector bench for hazard_detection_unit
module tb_hazard_detection_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ID_rs, ID_rt, EX_WriteRegister;
    logic        ID_UsesRt, ID_Branch, EX_RegWrite, EX_MemRead, MEM_Busy;
    logic        PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze;
    logic [31:0] StallCount;

    int vectors = 0;
    int errors  = 0;
    int stall_model = 0;

    hazard_detection_unit dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_WriteRegister(EX_WriteRegister), .MEM_Busy(MEM_Busy),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .Pipe_Freeze(Pipe_Freeze), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // Row: {rs, rt, uses_rt, branch, ex_regwrite, ex_memread, ex_wreg, mem_busy, {pc, ifid, bubble, freeze}}
    function automatic logic [23:0] vec(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic u, input logic b, input logic rw,
                                        input logic mr, input logic [4:0] wr,
                                        input logic busy, input logic [3:0] e);
        return {rs, rt, u, b, rw, mr, wr, busy, e};
    endfunction

    function automatic logic [31:0] exp_cnt();
        return PERF ? 32'(stall_model) : 32'd0;
    endfunction

    task automatic apply(input logic [23:0] v);
        {ID_rs, ID_rt, ID_UsesRt, ID_Branch, EX_RegWrite, EX_MemRead,
         EX_WriteRegister, MEM_Busy} = v[23:4];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(vec(5'd8, 5'd1, 1, 1, 1, 1, 5'd8, 1, 4'b0000));
        #3;
        vectors++;
        if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outs got=%b expected=%b", {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, 4'b1100);
        end
        @(posedge clk); #1;
        vectors++;
        if (StallCount !== 32'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d expected=0", StallCount);
        end
        apply(vec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 4'b0000));
        rst_n = 1'b1;
        stall_model = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        logic [23:0] tv [$];
        logic [23:0] v;
        tv = '{vec(5'd8, 5'd1, 1, 0, 1, 1, 5'd8, 0, 4'b0010),   // lw $8 ; add $9,$8,$1
               vec(5'd8, 5'd1, 1, 0, 0, 0, 5'd0, 0, 4'b1100),   // bubble in EX
               vec(5'd1, 5'd8, 1, 0, 1, 1, 5'd8, 0, 4'b0010),   // rt match
               vec(5'd1, 5'd8, 0, 0, 1, 1, 5'd8, 0, 4'b1100)};  // rt unused
        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            apply(v);
            #3;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== v[3:0]) begin
                errors++;
                $display("FAIL load_use[%0d] got=%b expected=%b", i, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, v[3:0]);
            end
            vectors++;
            if (StallCount !== exp_cnt()) begin
                errors++;
                $display("FAIL load_use_cnt[%0d] got=%0d expected=%0d", i, StallCount, exp_cnt());
            end
            if (!v[3]) stall_model++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_branch();
        logic [23:0] tv [$];
        logic [23:0] v;
        int start;
        start = stall_model;
        tv = '{vec(5'd8, 5'd2, 1, 1, 1, 1, 5'd8, 0, 4'b0010),   // lw $8 ; beq $8,$2
               vec(5'd8, 5'd2, 1, 1, 0, 0, 5'd0, 0, 4'b0010),   // second bubble, no hazard visible
               vec(5'd8, 5'd2, 1, 1, 1, 0, 5'd3, 0, 4'b1100),
               vec(5'd4, 5'd5, 1, 0, 0, 0, 5'd0, 0, 4'b1100)};
        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            apply(v);
            #3;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== v[3:0]) begin
                errors++;
                $display("FAIL load_branch[%0d] got=%b expected=%b", i, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, v[3:0]);
            end
            vectors++;
            if (StallCount !== exp_cnt()) begin
                errors++;
                $display("FAIL load_branch_cnt[%0d] got=%0d expected=%0d", i, StallCount, exp_cnt());
            end
            if (!v[3]) stall_model++;
            @(posedge clk); #1;
        end
        vectors++;
        if (stall_model - start != 2) begin
            errors++;
            $display("FAIL load_branch_total got=%0d expected=2", stall_model - start);
        end
    endtask

    task automatic test_zero_and_alu_branch();
        logic [23:0] tv [$];
        logic [23:0] v;
        tv = '{vec(5'd0, 5'd0, 1, 0, 1, 0, 5'd0, 0, 4'b1100),   // add writes $0, ID reads $0
               vec(5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 4'b1100),   // branch / load on $0
               vec(5'd5, 5'd6, 1, 1, 1, 0, 5'd5, 0, 4'b0010),   // add $5 ; beq $5,$6
               vec(5'd5, 5'd6, 1, 1, 0, 0, 5'd0, 0, 4'b1100),
               vec(5'd5, 5'd6, 1, 0, 1, 0, 5'd5, 0, 4'b1100),   // ALU dep, not a branch
               vec(5'd6, 5'd5, 1, 1, 1, 0, 5'd5, 0, 4'b0010)};  // branch dep on rt
        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            apply(v);
            #3;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== v[3:0]) begin
                errors++;
                $display("FAIL zero_alu_br[%0d] got=%b expected=%b", i, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, v[3:0]);
            end
            if (!v[3]) stall_model++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [23:0] tv [$];
        logic [23:0] v;
        tv = '{vec(5'd4, 5'd5, 1, 0, 0, 0, 5'd0, 1, 4'b0001),
               vec(5'd8, 5'd1, 1, 0, 1, 1, 5'd8, 1, 4'b0001),   // busy beats load hazard
               vec(5'd4, 5'd5, 1, 0, 0, 0, 5'd0, 0, 4'b1100),
               vec(5'd8, 5'd2, 1, 1, 1, 1, 5'd8, 0, 4'b0010),   // load-branch into STALL
               vec(5'd8, 5'd2, 1, 1, 0, 0, 5'd0, 1, 4'b0001),
               vec(5'd8, 5'd2, 1, 1, 0, 0, 5'd0, 1, 4'b0001),
               vec(5'd8, 5'd2, 1, 1, 0, 0, 5'd0, 1, 4'b0001),
               vec(5'd8, 5'd2, 1, 1, 0, 0, 5'd0, 0, 4'b0010),   // remaining bubble
               vec(5'd8, 5'd2, 1, 1, 0, 0, 5'd0, 0, 4'b1100)};
        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            apply(v);
            #3;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== v[3:0]) begin
                errors++;
                $display("FAIL mem_wait[%0d] got=%b expected=%b", i, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, v[3:0]);
            end
            vectors++;
            if (StallCount !== exp_cnt()) begin
                errors++;
                $display("FAIL mem_wait_cnt[%0d] got=%0d expected=%0d", i, StallCount, exp_cnt());
            end
            if (!v[3]) stall_model++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op();
        for (int k = 0; k < 2; k++) begin
            // k=0 aborts MEM_WAIT, k=1 aborts STALL
            if (k == 0) apply(vec(5'd4, 5'd5, 1, 0, 0, 0, 5'd0, 1, 4'b0001));
            else        apply(vec(5'd8, 5'd2, 1, 1, 1, 1, 5'd8, 0, 4'b0010));
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_mid[%0d] got=%b expected=%b", k, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, 4'b1100);
            end
            vectors++;
            if (StallCount !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_cnt[%0d] got=%0d expected=0", k, StallCount);
            end
            stall_model = 0;
            @(posedge clk); #1;
            apply(vec(5'd4, 5'd5, 1, 1, 0, 0, 5'd0, 0, 4'b1100));
            rst_n = 1'b1;
            #3;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_release[%0d] got=%b expected=%b", k, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, 4'b1100);
            end
            @(posedge clk); #1;
            #3;
            vectors++;
            if ({PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_no_bubble[%0d] got=%b expected=%b", k, {PCWrite, IF_ID_Write, ID_EX_Bubble, Pipe_Freeze}, 4'b1100);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) apply(vec(5'd8, 5'd1, 1, 0, 1, 1, 5'd8, 0, 4'b0010));
            else            apply(vec(5'd8, 5'd1, 1, 0, 0, 0, 5'd0, 0, 4'b1100));
            #3;
            vectors++;
            if (PCWrite !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL back_to_back[%0d] got=%b expected=%b", i, PCWrite, (i % 2 == 1));
            end
            vectors++;
            if (StallCount !== exp_cnt()) begin
                errors++;
                $display("FAIL back_to_back_cnt[%0d] got=%0d expected=%0d", i, StallCount, exp_cnt());
            end
            if (i % 2 == 0) stall_model++;
            @(posedge clk); #1;
        end
        #3;
        vectors++;
        if (StallCount !== exp_cnt()) begin
            errors++;
            $display("FAIL back_to_back_final got=%0d expected=%0d", StallCount, exp_cnt());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply(vec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 4'b0000));
        #1;
        test_reset();
        test_load_use();
        test_load_branch();
        test_zero_and_alu_branch();
        test_mem_wait();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
